// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-word to BCD converter: FSM states,
// constant-width helpers and the end-to-end latency expression.
package freq_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DABBLE, DONE} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    // Edges from the accepting edge to the edge that raises valid.
    function automatic int latency(input int fcw_w, input int scale);
        return fcw_w + clog2(scale) + 1;
    endfunction

    function automatic logic [63:0] pow10(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/freq_bcd_conv.sv
// Converts a frequency control word to floor(fcw*SCALE/2^FCW_W) in BCD using a
// bit-serial shift-add multiply followed by a bit-serial double dabble.
module freq_bcd_conv
    import freq_pkg::*;
#(
    parameter int FCW_W  = 12,
    parameter int SCALE  = 10000,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FCW_W-1:0]      fcw,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int RES_W = clog2(SCALE);
    localparam int ACC_W = FCW_W + RES_W;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(((FCW_W > RES_W) ? FCW_W : RES_W) + 1);
    localparam logic [ACC_W-1:0] SCALE_ACC = ACC_W'(SCALE);
    localparam logic [63:0]      BCD_LIMIT = pow10(DIGITS);

    state_t             state_q, state_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [RES_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]       dig_corr;
    logic [ACC_W-1:0]       acc_nxt;
    logic [RES_W-1:0]       res_nxt;
    logic [BCD_W+RES_W-1:0] shift_nxt;

    // The accumulator MSB is always zero while shifting; the product fits ACC_W.
    logic unused_acc_msb;
    assign unused_acc_msb = acc_q[ACC_W-1];

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (dig_q[4*i +: 4]),
            .digit_out (dig_corr[4*i +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        fcw_d      = fcw_q;
        acc_d      = acc_q;
        bin_d      = bin_q;
        dig_d      = dig_q;
        ovf_pend_d = ovf_pend_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        acc_nxt    = '0;
        res_nxt    = '0;
        shift_nxt  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MUL;
                    fcw_d   = fcw;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            MUL: begin
                // MSB-first shift-add: acc = 2*acc + bit*SCALE.
                acc_nxt = {acc_q[ACC_W-2:0], 1'b0} + (fcw_q[FCW_W-1] ? SCALE_ACC : '0);
                acc_d   = acc_nxt;
                fcw_d   = {fcw_q[FCW_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FCW_W - 1)) begin
                    res_nxt    = acc_nxt[ACC_W-1:FCW_W];
                    bin_d      = res_nxt;
                    dig_d      = '0;
                    ovf_pend_d = (64'(res_nxt) >= BCD_LIMIT);
                    cnt_d      = '0;
                    state_d    = DABBLE;
                end
            end
            DABBLE: begin
                shift_nxt  = {dig_corr[BCD_W-2:0], bin_q, 1'b0};
                dig_d      = shift_nxt[BCD_W+RES_W-1 -: BCD_W];
                bin_d      = shift_nxt[RES_W-1:0];
                ovf_pend_d = ovf_pend_q | dig_corr[BCD_W-1];
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RES_W - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : dig_q;
                ovf_d   = ovf_pend_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fcw_q      <= '0;
            acc_q      <= '0;
            bin_q      <= '0;
            dig_q      <= '0;
            ovf_pend_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcw_q      <= fcw_d;
            acc_q      <= acc_d;
            bin_q      <= bin_d;
            dig_q      <= dig_d;
            ovf_pend_q <= ovf_pend_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/freq_bcd_conv.md
FREQ_BCD_CONV -- requirements
Module: freq_bcd_conv

Interface
REQ-001 Parameter FCW_W, default 12: width of the frequency control word.
REQ-002 Parameter SCALE, default 10000: full-scale numerator (frequency for fcw = 2^FCW_W).
REQ-003 Parameter DIGITS, default 4: number of BCD output digits.
REQ-004 Derived constant RES_W = clog2(SCALE): width of the binary result.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  Rising-edge clock.
REQ-007 rst  in  1  Asynchronous, active-high reset.
REQ-008 start  in  1  Conversion request; sampled on clk.
REQ-009 fcw  in  FCW_W  Frequency control word; sampled only when start is accepted.
REQ-010 busy  out  1  High while a conversion is in progress.
REQ-011 valid  out  1  One-cycle pulse; bcd and ovf are updated in this cycle.
REQ-012 bcd  out  4*DIGITS  Result digits; digit 0 in bits [3:0], most significant digit at the top.
REQ-013 ovf  out  1  Result exceeded 10^DIGITS-1; held with bcd.

Function
REQ-014 Result SHALL be floor(fcw*SCALE / 2^FCW_W), i.e. the product right-shifted by FCW_W with truncation.
REQ-015 FSM states SHALL be IDLE, MUL, DABBLE, DONE; exit from reset is to IDLE.
REQ-016 IDLE with start=1: latch fcw, clear accumulator, enter MUL, and assert busy from that edge.
REQ-017 MUL: shift-add multiply, one multiplier bit per cycle, for exactly FCW_W cycles, then enter DABBLE.
REQ-018 DABBLE: double-dabble binary-to-BCD conversion, one bit per cycle, for exactly RES_W cycles, then enter DONE.
REQ-019 DONE: bcd/ovf registered, valid=1 for one cycle, busy=0, and return to IDLE on the next edge.
REQ-020 Latency: valid SHALL rise exactly FCW_W+RES_W+1 clock edges after the accepting edge (27 with the defaults).
REQ-021 start while busy=1 or in DONE SHALL be ignored; the in-flight fcw SHALL NOT change.
REQ-022 A start in the cycle immediately after valid SHALL be accepted (no dead cycle beyond DONE).
REQ-023 If the result is >= 10^DIGITS, bcd SHALL saturate to all 9s and ovf=1; otherwise ovf=0.
REQ-024 bcd/ovf SHALL hold their last values between valid pulses.
REQ-025 The multiply accumulator SHALL be FCW_W+RES_W bits wide, so no intermediate overflow is possible.
REQ-026 fcw=0 SHALL produce bcd=0 through the full latency; there is no early exit.

Reset
REQ-027 rst=1 SHALL force, asynchronously, state=IDLE, busy=0, valid=0, bcd=0, ovf=0, and clear all counters and datapath registers.
REQ-028 rst asserted mid-conversion SHALL abort it; no valid pulse for that request after rst is released.
REQ-029 The first start after rst is released SHALL be accepted normally.

Structure
REQ-030 Shared package freq_pkg SHALL hold the FSM state typedef, the clog2 function, and the latency constant expression.
REQ-031 One sub-module, bcd_add3, SHALL implement the per-digit "add 3 if >= 5" correction and be instantiated DIGITS times.
REQ-032 No divider or wide multiplier primitive SHALL be inferred; the datapath is shift-add only.

Verification
REQ-033 Defaults, fcw=4095, start pulse -> valid at +27 cycles, bcd=0x9997, ovf=0.
REQ-034 Defaults, fcw=2048 -> bcd=0x5000; fcw=1 -> bcd=0x0002; fcw=0 -> bcd=0x0000.
REQ-035 Defaults, start held high continuously with fcw changing every cycle -> one result per 28 cycles, each from the fcw captured at its accept edge.
REQ-036 SCALE=100000, DIGITS=4, fcw=4095 -> bcd=0x9999, ovf=1.
REQ-037 rst pulsed 10 cycles after accept -> no valid pulse, outputs 0; next start with fcw=1024 -> bcd=0x2500.
REQ-038 Random fcw over 1000 runs, compared against a reference model -> exact match and constant latency.
